// File: rtl/prom_pkg.sv
// Shared definitions for the PROM boot-copy path: PROM geometry and loader states.
package prom_pkg;

  localparam int PROM_ADDR_W = 10;
  localparam int PROM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/fifo2.sv
// Two-entry synchronous FIFO with first-word-fall-through head and
// simultaneous push/pop support.
module fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset only because it is two flops deep and the head must read zero after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prom_loader.sv
// Boot-time copy engine: sweeps the PROM through its one-cycle-latency read port
// and streams each word into main memory over a valid/ready write port.
module prom_loader
  import prom_pkg::*;
#(
  parameter int          ADDR_W    = PROM_ADDR_W,
  parameter int          DATA_W    = PROM_DATA_W,
  parameter int          WORDS     = 1024,
  parameter logic [31:0] DEST_BASE = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              prom_ce,
  output logic [ADDR_W-1:0] prom_adr,
  input  logic [DATA_W-1:0] prom_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [31:0]       mem_adr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

  loader_state_t     state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              inflight;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic [2:0]        pending;

  assign mem_valid = (state == RUN) && (fifo_count != 2'd0);
  assign pop       = mem_valid & mem_ready;

  // Words already buffered or in flight after this cycle's pop; a new read needs a free slot.
  assign pending   = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign prom_ce   = (state == RUN) && (rd_cnt < WORDS_C) && (pending < 3'd2);
  assign prom_adr  = rd_cnt[ADDR_W-1:0];

  assign mem_adr   = DEST_BASE + (32'(wr_cnt) << 2);
  assign mem_wdata = fifo_head;

  fifo2 #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (prom_data),
    .head  (fifo_head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= prom_ce;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (prom_ce) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
          if (pop) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_C) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Scoreboard bench for prom_loader: three instances (WORDS = 4, 1024, 1) share one clock;
// expected writes are queued at start and retired as the memory port accepts them.
module tb_prom_loader;

  localparam int N = 3;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic [N-1:0]   rst;
  logic [N-1:0]   start;
  logic           ready_a;
  logic           rand_bit;
  wire  [N-1:0]   ready = {1'b1, rand_bit, ready_a};
  wire  [N-1:0]   busy;
  wire  [N-1:0]   done;
  wire  [N-1:0]   ce;
  wire  [N-1:0]   valid;
  wire  [9:0]     adr   [N];
  wire  [31:0]    madr  [N];
  wire  [31:0]    wdata [N];

  wr_t            exp_q [N][$];
  logic [31:0]    mem_img [1024];

  int n_checks = 0;
  int n_fail   = 0;
  int e0        [N];
  int wr_seen   [N];
  int first_acc [N];
  int last_acc  [N];
  int done_cnt  [N];
  int done_cyc  [N];
  int busy_cnt  [N];
  int ce_win    [N];
  int ce_lo = 0;
  int ce_hi = -1;

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int words_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1024 : 1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 1024 : 1);
    logic [31:0] pd;
    logic        pv = 1'b0;
    logic [31:0] pa;
    logic [31:0] pw;

    prom_loader #(
      .ADDR_W(10), .DATA_W(32), .WORDS(W), .DEST_BASE(32'h100)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .prom_ce   (ce[g]),
      .prom_adr  (adr[g]),
      .prom_data (pd),
      .mem_valid (valid[g]),
      .mem_ready (ready[g]),
      .mem_adr   (madr[g]),
      .mem_wdata (wdata[g])
    );

    // PROM image: word i holds 0xA0000000 + i, registered one cycle after ce.
    always @(posedge clk) begin
      if (ce[g]) pd <= 32'hA000_0000 + {22'd0, adr[g]};
    end

    always @(negedge clk) begin
      int  n;
      int  idx;
      wr_t e;
      if (rst[g]) begin
        pv = 1'b0;
      end else begin
        n = (int'($time) - e0[g] - 5) / 10;
        check("fifo_count_le2", 64'(u_dut.u_fifo.count <= 2'd2), 64'd1);
        if (ce[g]) check("prom_adr_range", 64'({22'd0, adr[g]} < W), 64'd1);
        if (pv) begin
          check("hold_valid", 64'(valid[g]), 64'd1);
          check("hold_adr",   64'(madr[g]),  64'(pa));
          check("hold_data",  64'(wdata[g]), 64'(pw));
        end
        if (busy[g]) busy_cnt[g]++;
        if (done[g]) begin
          done_cnt[g]++;
          done_cyc[g] = n;
        end
        if (ce[g] && n >= ce_lo && n <= ce_hi) ce_win[g]++;
        if (valid[g] && ready[g]) begin
          check("write_expected", 64'(exp_q[g].size() > 0), 64'd1);
          if (exp_q[g].size() > 0) begin
            e = exp_q[g].pop_front();
            check("wr_adr",  64'(madr[g]),  64'(e.adr));
            check("wr_data", 64'(wdata[g]), 64'(e.data));
          end
          if (g == 1) begin
            idx = int'((madr[g] - 32'h100) >> 2);
            if (idx >= 0 && idx < 1024) mem_img[idx] = wdata[g];
          end
          wr_seen[g]++;
          if (wr_seen[g] == 1) first_acc[g] = n + 1;
          last_acc[g] = n + 1;
          pv = 1'b0;
        end else begin
          pv = valid[g];
          pa = madr[g];
          pw = wdata[g];
        end
      end
    end
  end

  // Queues the full expected write stream, then raises start so the next edge is E0.
  task automatic kick(input int g);
    for (int i = 0; i < words_of(g); i++) begin
      exp_q[g].push_back({32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
    end
    wr_seen[g]  = 0;
    first_acc[g] = -1;
    last_acc[g] = -1;
    done_cnt[g] = 0;
    done_cyc[g] = -1;
    busy_cnt[g] = 0;
    ce_win[g]   = 0;
    @(posedge clk);
    #1;
    start[g] = 1'b1;
    @(posedge clk);
    e0[g] = int'($time);
    #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int k = 0;
    while (!done[g] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", 64'(done[g]), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_rst(input int g);
    check("rst_busy",      64'(busy[g]),  64'd0);
    check("rst_done",      64'(done[g]),  64'd0);
    check("rst_prom_ce",   64'(ce[g]),    64'd0);
    check("rst_prom_adr",  64'(adr[g]),   64'd0);
    check("rst_mem_valid", 64'(valid[g]), 64'd0);
    check("rst_mem_adr",   64'(madr[g]),  64'h100);
    check("rst_mem_wdata", 64'(wdata[g]), 64'd0);
  endtask

  task automatic check_run(input string tag, input int g, input int wr, input int first,
                           input int last, input int dcyc, input int bcnt);
    check({tag, "_writes"},     64'(wr_seen[g]),       64'(wr));
    check({tag, "_first_edge"}, 64'(first_acc[g]),     64'(first));
    check({tag, "_last_edge"},  64'(last_acc[g]),      64'(last));
    check({tag, "_done_cycle"}, 64'(done_cyc[g]),      64'(dcyc));
    check({tag, "_done_pulses"}, 64'(done_cnt[g]),     64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt[g]),     64'(bcnt));
    check({tag, "_queue_empty"}, 64'(exp_q[g].size()), 64'd0);
  endtask

  initial begin
    rst      = '1;
    start    = '0;
    ready_a  = 1'b1;
    rand_bit = 1'b0;
    #12;
    check_rst(0);
    @(posedge clk);
    #1;
    rst = '0;
    repeat (2) @(posedge clk);

    // Streaming with ready held high.
    kick(0);
    wait_done(0, 50);
    check_run("stream", 0, 4, 3, 6, 6, 6);

    // Backpressure: ready low in cycles 3..8.
    ce_lo = 3;
    ce_hi = 8;
    kick(0);
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1;
      ready_a = !(n >= 3 && n <= 8);
      if (n == 8) begin
        #3;
        check("bp_buffered", 64'(g_dut[0].u_dut.u_fifo.count), 64'd2);
      end
    end
    wait_done(0, 50);
    check_run("bp", 0, 4, 3, 12, 12, 12);
    check("bp_ce_stalled", 64'(ce_win[0]), 64'd0);
    ce_hi = -1;

    // Second start pulse during RUN must be ignored.
    kick(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, 50);
    check_run("restart_ignored", 0, 4, 3, 6, 6, 6);

    // Asynchronous reset after two accepted writes, then a clean restart.
    kick(0);
    repeat (4) @(posedge clk);
    #2;
    rst[0] = 1'b1;
    #1;
    check_rst(0);
    check("rst_mid_writes",  64'(wr_seen[0]),       64'd2);
    check("rst_mid_pending", 64'(exp_q[0].size()),  64'd2);
    exp_q[0].delete();
    repeat (5) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    repeat (4) @(posedge clk);
    check("no_write_after_rst", 64'(wr_seen[0]), 64'd2);
    kick(0);
    wait_done(0, 50);
    check_run("after_rst", 0, 4, 3, 6, 6, 6);

    // Full-size copy under random backpressure.
    kick(1);
    wait_done(1, 20000);
    check("rand_writes",      64'(wr_seen[1]),      64'd1024);
    check("rand_done_pulses", 64'(done_cnt[1]),     64'd1);
    check("rand_queue_empty", 64'(exp_q[1].size()), 64'd0);
    for (int i = 0; i < 1024; i++) begin
      check("mem_image", 64'(mem_img[i]), 64'(32'hA000_0000 + 32'(i)));
    end

    // Single-word copy.
    kick(2);
    wait_done(2, 20);
    check_run("one_word", 2, 1, 3, 3, 3, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prom_loader.md
# prom_loader

Boot-time copy engine that is the read-side initiator of the 32-bit PROM: it sweeps the PROM address space using its one-cycle-latency `ce`/`adr`/`data` read port and streams every word into main memory through a valid/ready write port. It sits between the PROM and the memory arbiter, is kicked once by the reset/boot controller, and signals completion so the CPU can be released.

## Interface

- `ADDR_W`, 10: PROM address width.
- `DATA_W`, 32: word width.
- `WORDS`, 1024: words to copy, legal range 1..2^ADDR_W.
- `DEST_BASE`, 32'h0: byte address of the first destination word, 4-byte aligned.

- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin copy, sampled only in IDLE.
- `busy`  out  1: copy in progress.
- `done`  out  1: one-cycle completion pulse.
- `prom_ce`  out  1: PROM read enable.
- `prom_adr`  out  ADDR_W: PROM word address.
- `prom_data`  in  DATA_W: PROM read data, valid the cycle after `prom_ce`.
- `mem_valid`  out  1: write request.
- `mem_ready`  in  1: memory accepts the request.
- `mem_adr`  out  32: destination byte address.
- `mem_wdata`  out  DATA_W: write data.

## Operation

- States: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1 at an edge. `start` is ignored in RUN and DONE.
- RUN → DONE on the edge where write number WORDS−1 is accepted.
- DONE → IDLE unconditionally after one cycle.
- Counters:
  - `rd_cnt`: reads issued, 0..WORDS.
  - `wr_cnt`: writes accepted, 0..WORDS.
  - Both are cleared on entry to RUN.
- Buffering: 2-entry FIFO holds returned PROM words, plus a 1-bit `inflight` flag for a read issued last cycle.
- Read issue:
  - Condition: `prom_ce` = RUN and `rd_cnt` < WORDS and (fifo_count + `inflight` − pop) < 2, where pop = `mem_valid` & `mem_ready`.
  - `prom_adr` = `rd_cnt[ADDR_W-1:0]`.
  - `rd_cnt` increments when `prom_ce`=1.
- Capture: when `inflight`=1, `prom_data` is pushed into the FIFO at that edge. Push and pop in the same cycle are legal and leave the count unchanged.
- Write side:
  - `mem_valid` = FIFO non-empty.
  - `mem_wdata` = FIFO head.
  - `mem_adr` = DEST_BASE + 4·`wr_cnt`, in 32-bit arithmetic that wraps modulo 2^32.
  - Once `mem_valid` rises, `mem_valid`, `mem_adr` and `mem_wdata` stay stable until accepted.
- Outputs per state:
  - `busy` = 1 in RUN only.
  - `done` = 1 in DONE only.
  - In IDLE and DONE, `prom_ce`=0 and `mem_valid`=0.
- Overflow guards:
  - Reads are never issued past WORDS.
  - The FIFO never overflows: the credit rule guarantees this, and the bench asserts it.
- Reset, including mid-copy: state IDLE, counters 0, FIFO empty, `inflight`=0. No partial word is written afterward. The copy is not resumable; a new `start` restarts from word 0.

## Timing

- Reset values: `busy`=0, `done`=0, `prom_ce`=0, `prom_adr`=0, `mem_valid`=0, `mem_adr`=DEST_BASE, `mem_wdata`=0.
- Start is sampled at edge E0. Then:
  - `prom_ce`=1 with `prom_adr`=0 in the cycle after E0.
  - The PROM registers data at E1, and it is pushed at E2.
  - `mem_valid` is high from E2 onward.
- With `mem_ready` held at 1:
  - One word is accepted per cycle, word k at E(k+3).
  - `done` is high in the cycle after E(WORDS+2).
  - Total is WORDS+3 cycles from E0 to the `done` cycle.
- Backpressure: with `mem_ready`=0, at most 2 words are buffered and reads stall (`prom_ce`=0). When `mem_ready` returns to 1, throughput resumes at 1 word/cycle with no bubble.

## Structure

- Shared package `prom_pkg`:
  - `PROM_ADDR_W`=10, `PROM_DATA_W`=32.
  - Loader state enum (IDLE, RUN, DONE).
- One sub-module `fifo2`: 2-entry synchronous FIFO parameterised on width, with async active-high reset, push/pop/count/head ports, and simultaneous push+pop supported.

## Test plan

- WORDS=4, DEST_BASE=0x100, PROM word i = 0xA0000000+i, `mem_ready`=1:
  - Writes (0x100,0xA0000000) … (0x10C,0xA0000003), one per cycle, first at E3.
  - `done` is a single pulse in the cycle after E6.
  - `busy` is high exactly 6 cycles.
- Same setup, `mem_ready` low for cycles 3–8:
  - `mem_valid`/`mem_adr`/`mem_wdata` held stable.
  - `prom_ce` drops once 2 words are buffered.
  - All 4 words are written in order, with no duplicate and no loss.
- Random `mem_ready` (50%), WORDS=1024:
  - Memory model equals the PROM image.
  - FIFO count never exceeds 2.
  - `prom_adr` never exceeds 1023.
- `start` pulsed again during RUN: no restart, same write sequence and `done` timing as with a single start.
- `rst` asserted mid-copy after 2 writes:
  - All outputs return to reset values asynchronously.
  - No further writes occur.
  - A subsequent `start` rewrites from DEST_BASE word 0.
- WORDS=1: exactly one write at E3, `done` in the cycle after E3.
